mem_req_sched: RTL and testbench

//  Sequences the shared memory_system port between the load queue and the store queue.

---
 rtl/mem_req_sched.sv | 184 ++++++++++++++++++
 tb/tb_mem_req_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sched.sv
// mem_req_sched: arbitrates the shared memory_system port between the load
// queue and the store queue. Loads win by default; a saturating age counter
// forces a pending store through after STR_MAX_WAIT lost arbitrations.
// Optional watchdog: define MEM_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles without done and raise a sticky o_tmo_err.
//
// Handshake: i_ld_req / i_str_req are level requests that the queues hold until
// they see their grant. A grant (o_ld_grnt / o_str_grnt) rises one cycle after
// arbitration, together with the 1-cycle o_enable strobe. It stays high until
// the cycle in which i_done is sampled high, so a queue may qualify i_done
// with its own grant. i_done is only meaningful while a grant is high.
module mem_req_sched #(
    parameter int STR_MAX_WAIT = 4,
    parameter int CW           = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ld_req,
    input  logic          i_str_req,
    input  logic          i_idle,
    input  logic          i_done,
    input  logic          i_flsh,
    output logic          o_ld_grnt,
    output logic          o_str_grnt,
    output logic          o_addr_sel,
    output logic          o_rd_wrt_ca,
    output logic          o_enable,
    output logic          o_busy,
    output logic [15:0]   o_ld_cnt,
    output logic [15:0]   o_str_cnt,
    output logic          o_tmo_err,
    output logic [1:0]    o_dbg_state,
    output logic [CW-1:0] o_dbg_age
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sel_str;   // owner of the current transaction: 1 = store
    logic [CW-1:0] r_age;
    logic [15:0]   r_ld_cnt;
    logic [15:0]   r_str_cnt;

    logic w_arb;
    logic w_str_win;
    logic w_age_max;
    logic w_done;
    logic w_tmo;
    logic w_in_txn;

    // Arbitration is only evaluated from IDLE with a ready memory system
    assign w_arb     = (r_state == S_IDLE) && i_idle && (i_ld_req || i_str_req) && !i_flsh;
    assign w_age_max = (r_age == CW'(STR_MAX_WAIT));
    assign w_str_win = i_str_req && (!i_ld_req || w_age_max);
    assign w_done    = (r_state == S_WAIT) && i_done;
    assign w_in_txn  = (r_state != S_IDLE);

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] r_wdog;
    logic          r_tmo_err;

    // Abort on the edge that closes the TIMEOUT-th WAIT cycle without done
    assign w_tmo = (r_state == S_WAIT) && !i_done && (r_wdog == TW'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles, restarting on every entry to WAIT
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wdog    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + TW'(1);
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign o_tmo_err = r_tmo_err;
`else
    localparam logic [31:0] TMO_L = TIMEOUT;

    logic w_unused_tmo;

    // Without the watchdog WAIT lasts until done; TIMEOUT has no effect
    assign w_unused_tmo = ^TMO_L;
    assign w_tmo        = 1'b0;
    assign o_tmo_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arb) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_done || w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the arbitration winner; it is held for the whole transaction
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sel_str <= 1'b0;
        end else if (w_arb) begin
            r_sel_str <= w_str_win;
        end
    end

    // Store age: counts loads that beat a pending store, saturating at the limit
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_age <= '0;
        end else if (i_flsh) begin
            r_age <= '0;
        end else if (w_arb) begin
            if (w_str_win) begin
                r_age <= '0;
            end else if (i_str_req && !w_age_max) begin
                r_age <= r_age + CW'(1);
            end
        end
    end

    // Completion counters, stepped on the done cycle of the owning class
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ld_cnt  <= '0;
            r_str_cnt <= '0;
        end else if (w_done) begin
            if (r_sel_str) begin
                r_str_cnt <= r_str_cnt + 16'd1;
            end else begin
                r_ld_cnt <= r_ld_cnt + 16'd1;
            end
        end
    end

    // Outputs are decoded from registered state only; no input-to-output paths
    assign o_ld_grnt   = w_in_txn && !r_sel_str;
    assign o_str_grnt  = w_in_txn && r_sel_str;
    assign o_addr_sel  = w_in_txn && r_sel_str;
    assign o_rd_wrt_ca = w_in_txn && r_sel_str;
    assign o_enable    = (r_state == S_ISSUE);
    assign o_busy      = w_in_txn;
    assign o_ld_cnt    = r_ld_cnt;
    assign o_str_cnt   = r_str_cnt;
    assign o_dbg_state = r_state;
    assign o_dbg_age   = r_age;

endmodule

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched: directed vector table plus hand-written multi-cycle
// sequences (store aging, flush during WAIT, watchdog) for mem_req_sched.
module tb_mem_req_sched;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, ld_req, str_req, idle, done, flsh;
    logic          ld_grnt, str_grnt, addr_sel, rd_wrt_ca, enable, busy, tmo_err;
    logic [15:0]   ld_cnt, str_cnt;
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_age;

    int n_vec = 0;
    int n_err = 0;

    mem_req_sched #(.STR_MAX_WAIT(4), .CW(CW), .TIMEOUT(15)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ld_req   (ld_req),
        .i_str_req  (str_req),
        .i_idle     (idle),
        .i_done     (done),
        .i_flsh     (flsh),
        .o_ld_grnt  (ld_grnt),
        .o_str_grnt (str_grnt),
        .o_addr_sel (addr_sel),
        .o_rd_wrt_ca(rd_wrt_ca),
        .o_enable   (enable),
        .o_busy     (busy),
        .o_ld_cnt   (ld_cnt),
        .o_str_cnt  (str_cnt),
        .o_tmo_err  (tmo_err),
        .o_dbg_state(dbg_state),
        .o_dbg_age  (dbg_age)
    );

    // clock
    always #5 clk = ~clk;

    // in  = {rst, ld_req, str_req, idle, done, flsh}
    // ex  = {ld_grnt, str_grnt, addr_sel, rd_wrt_ca, enable, busy}
    typedef struct {
        string       nm;
        logic [5:0]  in;
        logic [5:0]  ex;
        logic [15:0] lc;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string nm, logic [5:0] in, logic [5:0] ex, int lc, int sc);
        vec_t v;
        v.nm = nm;
        v.in = in;
        v.ex = ex;
        v.lc = 16'(lc);
        v.sc = 16'(sc);
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // advance one clock; sampling happens 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic [5:0] in);
        {rst, ld_req, str_req, idle, done, flsh} = in;
    endtask

    task automatic do_reset();
        set_in(6'b0_11100);
        tick();
        tick();
        rst = 1'b1;
        ld_req = 1'b0;
        str_req = 1'b0;
    endtask

    function automatic logic [5:0] flags();
        return {ld_grnt, str_grnt, addr_sel, rd_wrt_ca, enable, busy};
    endfunction

    initial begin
        set_in(6'b0_11100);

        // ---------------- directed table ----------------
        add("rst_a",       6'b0_11100, 6'b000000, 0, 0);
        add("rst_b",       6'b0_11100, 6'b000000, 0, 0);
        add("first_ld",    6'b1_11100, 6'b100011, 0, 0);
        add("t1_wait",     6'b1_00100, 6'b100001, 0, 0);
        add("t1_done",     6'b1_00110, 6'b000000, 1, 0);
        add("t2_issue",    6'b1_10100, 6'b100011, 1, 0);
        for (int i = 0; i < 4; i++) add("t2_wait", 6'b1_00100, 6'b100001, 1, 0);
        add("t2_done",     6'b1_00110, 6'b000000, 2, 0);
        add("stray_done",  6'b1_00010, 6'b000000, 2, 0);
        for (int i = 0; i < 10; i++) add("idle_gate", 6'b1_10000, 6'b000000, 2, 0);
        add("idle_go",     6'b1_10100, 6'b100011, 2, 0);
        add("t5_wait",     6'b1_00100, 6'b100001, 2, 0);
        add("t5_done",     6'b1_00110, 6'b000000, 3, 0);
        add("st_issue",    6'b1_01100, 6'b011111, 3, 0);
        add("st_wait",     6'b1_00100, 6'b011101, 3, 0);
        add("st_done",     6'b1_00110, 6'b000000, 3, 1);
        add("flsh_idle",   6'b1_10101, 6'b000000, 3, 1);
        add("after_flsh",  6'b1_10100, 6'b100011, 3, 1);
        add("fl_wait",     6'b1_00100, 6'b100001, 3, 1);
        add("fl_done",     6'b1_00110, 6'b000000, 4, 1);
        add("b2b_issue",   6'b1_10100, 6'b100011, 4, 1);
        add("b2b_wait",    6'b1_10100, 6'b100001, 4, 1);
        add("b2b_done",    6'b1_10110, 6'b000000, 5, 1);
        add("b2b_regrant", 6'b1_10100, 6'b100011, 5, 1);
        add("b2b_wait2",   6'b1_00100, 6'b100001, 5, 1);
        add("b2b_done2",   6'b1_00110, 6'b000000, 6, 1);

        foreach (tbl[i]) begin
            set_in(tbl[i].in);
            tick();
            chk({tbl[i].nm, "_flags"}, 32'(flags()), 32'(tbl[i].ex));
            chk({tbl[i].nm, "_ldcnt"}, 32'(ld_cnt), 32'(tbl[i].lc));
            chk({tbl[i].nm, "_stcnt"}, 32'(str_cnt), 32'(tbl[i].sc));
            chk({tbl[i].nm, "_tmo"}, 32'(tmo_err), 32'd0);
        end

        // ---------------- store aging: L,L,L,L,S,L ----------------
        do_reset();
        ld_req = 1'b1;
        str_req = 1'b1;
        idle = 1'b1;
        for (int g = 0; g < 6; g++) begin
            int  waited;
            logic exp_s;
            exp_s = (g == 4);
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!enable && waited < 6);
            chk($sformatf("age_g%0d_enable", g), 32'(enable), 32'd1);
            chk($sformatf("age_g%0d_grant", g), 32'({ld_grnt, str_grnt}), 32'({!exp_s, exp_s}));
            chk($sformatf("age_g%0d_sel", g), 32'({addr_sel, rd_wrt_ca}), 32'({exp_s, exp_s}));
            tick();
            tick();
            done = 1'b1;
            chk($sformatf("age_g%0d_done_grant", g), 32'({ld_grnt, str_grnt}), 32'({!exp_s, exp_s}));
            tick();
            done = 1'b0;
        end
        chk("age_ldcnt", 32'(ld_cnt), 32'd5);
        chk("age_stcnt", 32'(str_cnt), 32'd1);

        // ---------------- flush during WAIT ----------------
        do_reset();
        ld_req = 1'b1;
        str_req = 1'b1;
        tick();
        chk("fw_issue", 32'(flags()), 32'(6'b100011));
        chk("fw_age1", 32'(dbg_age), 32'd1);
        ld_req = 1'b0;
        str_req = 1'b0;
        tick();
        ld_req = 1'b1;
        str_req = 1'b1;
        flsh = 1'b1;
        tick();
        chk("fw_hold", 32'(flags()), 32'(6'b100001));
        chk("fw_state", 32'(dbg_state), 32'd2);
        chk("fw_age0", 32'(dbg_age), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fw_done_idle", 32'(flags()), 32'(6'b000000));
        chk("fw_ldcnt", 32'(ld_cnt), 32'd1);
        tick();
        chk("fw_blocked", 32'(flags()), 32'(6'b000000));
        flsh = 1'b0;
        tick();
        chk("fw_resume_ld", 32'(flags()), 32'(6'b100011));
        ld_req = 1'b0;
        str_req = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fw_ldcnt2", 32'(ld_cnt), 32'd2);

`ifdef MEM_SCHED_TIMEOUT_EN
        // ---------------- watchdog abort ----------------
        do_reset();
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("wd_still_wait", 32'({busy, tmo_err}), 32'(2'b10));
        tick();
        chk("wd_abort", 32'({flags(), tmo_err}), 32'(7'b0000001));
        chk("wd_ldcnt", 32'(ld_cnt), 32'd0);
        ld_req = 1'b1;
        tick();
        chk("wd_next_issue", 32'(flags()), 32'(6'b100011));
        ld_req = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("wd_next_done", 32'({ld_cnt[1:0], tmo_err}), 32'(3'b011));
`else
        // ---------------- long WAIT without watchdog ----------------
        do_reset();
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("nowd_wait", 32'({flags(), tmo_err}), 32'(7'b1000010));
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("nowd_done", 32'(ld_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
